pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the RV32 core; drives the hold/redirect inputs of the instruction-fetch stage and the flush/bubble/hold controls of the ID and EX stages.
- Resolves load-use hazards, taken branches and jumps, multi-cycle execute ops (div/mul), and external halt/resume.
- Sits beside the datapath: hazard inputs arrive from ID/EX, and outputs feed IF, ID and EX directly.

---
 rtl/pipe_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: turns hazard, redirect, multi-cycle and debug-halt
// events into hold/flush/bubble controls for the IF, ID and EX stages.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MC_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic        ID_rs1_used,
  input  logic        ID_rs2_used,
  input  logic        EX_is_load,
  input  logic [4:0]  EX_rd,
  input  logic        EX_br_taken,
  input  logic [31:0] EX_br_target,
  input  logic        EX_mc_start,
  input  logic        mc_done,
  input  logic        halt_req,
  input  logic        resume_req,
  output logic        IF_hold,
  output logic        IF_jmp_vld,
  output logic [31:0] IF_jmp_addr,
  output logic        ID_flush,
  output logic        EX_bubble,
  output logic        pipe_hold,
  output logic        halted,
  output logic        mc_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_MC_WAIT, S_HALT} state_t;

  localparam logic [1:0] FC      = 2'(FLUSH_CYCLES);
  localparam logic [7:0] MC_LAST = 8'(MC_TIMEOUT - 1);

  state_t      state, state_nx;
  logic [1:0]  flush_cnt, flush_cnt_nx;
  logic [7:0]  mc_cnt, mc_cnt_nx;
  logic        halt_pend, halt_pend_nx;
  logic        timeout_q, timeout_nx;
  logic [31:0] stall_q;
  logic        load_use;
  logic        hold_c, jv_c, flush_c, bub_c, phold_c, halted_c;

  always_comb begin
    load_use = EX_is_load && (EX_rd != 5'd0) &&
               ((ID_rs1_used && (ID_rs1 == EX_rd)) ||
                (ID_rs2_used && (ID_rs2 == EX_rd)));
  end

  always_comb begin
    state_nx     = state;
    flush_cnt_nx = flush_cnt;
    mc_cnt_nx    = mc_cnt;
    halt_pend_nx = halt_pend;
    timeout_nx   = timeout_q;
    hold_c       = 1'b0;
    jv_c         = 1'b0;
    flush_c      = 1'b0;
    bub_c        = 1'b0;
    phold_c      = 1'b0;
    halted_c     = 1'b0;
    case (state)
      S_RUN: begin
        if (EX_br_taken) begin
          jv_c         = 1'b1;
          flush_c      = 1'b1;
          bub_c        = 1'b1;
          flush_cnt_nx = FC;
          state_nx     = (FC != 2'd0) ? S_FLUSH : S_RUN;
        end else if (EX_mc_start) begin
          hold_c    = 1'b1;
          phold_c   = 1'b1;
          mc_cnt_nx = '0;
          state_nx  = S_MC_WAIT;
        end else if (load_use) begin
          hold_c = 1'b1;
          bub_c  = 1'b1;
        end else if (halt_req) begin
          state_nx = S_HALT;
        end
      end
      S_FLUSH: begin
        flush_c = 1'b1;
        if (EX_br_taken) begin
          jv_c         = 1'b1;
          bub_c        = 1'b1;
          flush_cnt_nx = FC;
          halt_pend_nx = halt_pend | halt_req;
        end else if (flush_cnt == 2'd1) begin
          // A level halt_req is re-sampled in RUN, so a pending halt is dropped here.
          state_nx     = S_RUN;
          halt_pend_nx = 1'b0;
        end else begin
          flush_cnt_nx = flush_cnt - 2'd1;
          halt_pend_nx = halt_pend | halt_req;
        end
      end
      S_MC_WAIT: begin
        hold_c  = 1'b1;
        phold_c = 1'b1;
        if (mc_done) begin
          state_nx     = halt_pend ? S_HALT : S_RUN;
          halt_pend_nx = 1'b0;
        end else if (mc_cnt == MC_LAST) begin
          timeout_nx   = 1'b1;
          state_nx     = S_RUN;
          halt_pend_nx = 1'b0;
        end else begin
          mc_cnt_nx    = mc_cnt + 8'd1;
          halt_pend_nx = halt_pend | halt_req;
        end
      end
      S_HALT: begin
        hold_c   = 1'b1;
        phold_c  = 1'b1;
        halted_c = 1'b1;
        if (resume_req) state_nx = S_RUN;
      end
      default: state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_RUN;
      flush_cnt <= '0;
      mc_cnt    <= '0;
      halt_pend <= 1'b0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state     <= state_nx;
      flush_cnt <= flush_cnt_nx;
      mc_cnt    <= mc_cnt_nx;
      halt_pend <= halt_pend_nx;
      timeout_q <= timeout_nx;
      stall_q   <= stall_q + {31'd0, hold_c};
    end
  end

  always_comb begin
    IF_hold      = rst_n & hold_c;
    IF_jmp_vld   = rst_n & jv_c;
    IF_jmp_addr  = (rst_n && jv_c) ? EX_br_target : '0;
    ID_flush     = rst_n & flush_c;
    EX_bubble    = rst_n & bub_c;
    pipe_hold    = rst_n & phold_c;
    halted       = rst_n & halted_c;
    mc_timeout   = rst_n & timeout_q;
    stall_cycles = rst_n ? stall_q : '0;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (FLUSH_CYCLES=1/MC_TIMEOUT=64 and
// FLUSH_CYCLES=0/MC_TIMEOUT=8) share stimulus and are checked every cycle.
module tb_pipe_ctrl;

  localparam int unsigned FC_A = 1;
  localparam int unsigned TO_A = 64;
  localparam int unsigned FC_B = 0;
  localparam int unsigned TO_B = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ID_rs1, ID_rs2, EX_rd;
  logic        ID_rs1_used, ID_rs2_used, EX_is_load;
  logic        EX_br_taken, EX_mc_start, mc_done, halt_req, resume_req;
  logic [31:0] EX_br_target;

  logic        hold_o [2];
  logic        jv_o   [2];
  logic [31:0] addr_o [2];
  logic        fl_o   [2];
  logic        bub_o  [2];
  logic        ph_o   [2];
  logic        hl_o   [2];
  logic        to_o   [2];
  logic [31:0] st_o   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(FC_A), .MC_TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .EX_is_load(EX_is_load), .EX_rd(EX_rd), .EX_br_taken(EX_br_taken),
    .EX_br_target(EX_br_target), .EX_mc_start(EX_mc_start), .mc_done(mc_done),
    .halt_req(halt_req), .resume_req(resume_req),
    .IF_hold(hold_o[0]), .IF_jmp_vld(jv_o[0]), .IF_jmp_addr(addr_o[0]),
    .ID_flush(fl_o[0]), .EX_bubble(bub_o[0]), .pipe_hold(ph_o[0]),
    .halted(hl_o[0]), .mc_timeout(to_o[0]), .stall_cycles(st_o[0])
  );

  pipe_ctrl #(.FLUSH_CYCLES(FC_B), .MC_TIMEOUT(TO_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .EX_is_load(EX_is_load), .EX_rd(EX_rd), .EX_br_taken(EX_br_taken),
    .EX_br_target(EX_br_target), .EX_mc_start(EX_mc_start), .mc_done(mc_done),
    .halt_req(halt_req), .resume_req(resume_req),
    .IF_hold(hold_o[1]), .IF_jmp_vld(jv_o[1]), .IF_jmp_addr(addr_o[1]),
    .ID_flush(fl_o[1]), .EX_bubble(bub_o[1]), .pipe_hold(ph_o[1]),
    .halted(hl_o[1]), .mc_timeout(to_o[1]), .stall_cycles(st_o[1])
  );

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Reference model: per-instance flags and counters advanced once per cycle.
  bit          m_mc   [2];
  int unsigned m_age  [2];
  int unsigned m_fl   [2];
  bit          m_halt [2];
  bit          m_pend [2];
  bit          m_to   [2];
  logic [31:0] m_st   [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_mc[i] = 0; m_age[i] = 0; m_fl[i] = 0; m_halt[i] = 0;
      m_pend[i] = 0; m_to[i] = 0; m_st[i] = '0;
    end
  end

  always @(negedge clk) begin : compare
    bit e_hold, e_jv, e_fl, e_bub, e_ph, e_hl, lu;
    logic [31:0] e_addr;
    int unsigned fc, tlim;
    for (int i = 0; i < 2; i++) begin
      fc   = (i == 0) ? FC_A : FC_B;
      tlim = (i == 0) ? TO_A : TO_B;
      lu = EX_is_load && (EX_rd != 0) &&
           ((ID_rs1_used && ID_rs1 == EX_rd) || (ID_rs2_used && ID_rs2 == EX_rd));
      e_hold = 0; e_jv = 0; e_fl = 0; e_bub = 0; e_ph = 0; e_hl = 0; e_addr = '0;
      if (rst_n) begin
        if (m_halt[i]) begin
          e_hold = 1; e_ph = 1; e_hl = 1;
        end else if (m_mc[i]) begin
          e_hold = 1; e_ph = 1;
        end else if (EX_br_taken) begin
          e_jv = 1; e_addr = EX_br_target; e_fl = 1; e_bub = 1;
        end else if (m_fl[i] > 0) begin
          e_fl = 1;
        end else if (EX_mc_start) begin
          e_hold = 1; e_ph = 1;
        end else if (lu) begin
          e_hold = 1; e_bub = 1;
        end
      end
      chk("IF_hold", i, {31'd0, hold_o[i]}, {31'd0, e_hold});
      chk("IF_jmp_vld", i, {31'd0, jv_o[i]}, {31'd0, e_jv});
      chk("IF_jmp_addr", i, addr_o[i], e_addr);
      chk("ID_flush", i, {31'd0, fl_o[i]}, {31'd0, e_fl});
      chk("EX_bubble", i, {31'd0, bub_o[i]}, {31'd0, e_bub});
      chk("pipe_hold", i, {31'd0, ph_o[i]}, {31'd0, e_ph});
      chk("halted", i, {31'd0, hl_o[i]}, {31'd0, e_hl});
      chk("mc_timeout", i, {31'd0, to_o[i]}, {31'd0, rst_n & m_to[i]});
      chk("stall_cycles", i, st_o[i], rst_n ? m_st[i] : 32'd0);

      if (!rst_n) begin
        m_mc[i] = 0; m_age[i] = 0; m_fl[i] = 0; m_halt[i] = 0;
        m_pend[i] = 0; m_to[i] = 0; m_st[i] = '0;
      end else begin
        m_st[i] = m_st[i] + (e_hold ? 32'd1 : 32'd0);
        if (m_halt[i]) begin
          if (resume_req) m_halt[i] = 0;
        end else if (m_mc[i]) begin
          if (mc_done) begin
            m_mc[i] = 0; m_halt[i] = m_pend[i]; m_pend[i] = 0;
          end else if (m_age[i] == tlim - 1) begin
            m_mc[i] = 0; m_to[i] = 1; m_pend[i] = 0;
          end else begin
            m_age[i]++;
            if (halt_req) m_pend[i] = 1;
          end
        end else if (EX_br_taken) begin
          if (m_fl[i] > 0 && halt_req) m_pend[i] = 1;
          m_fl[i] = fc;
        end else if (m_fl[i] > 0) begin
          if (m_fl[i] == 1) begin
            m_fl[i] = 0; m_pend[i] = 0;
          end else begin
            m_fl[i]--;
            if (halt_req) m_pend[i] = 1;
          end
        end else if (EX_mc_start) begin
          m_mc[i] = 1; m_age[i] = 0;
        end else if (!lu && halt_req) begin
          m_halt[i] = 1;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic probe;
    @(negedge clk);
    #1;
  endtask

  task automatic idle;
    ID_rs1 = '0; ID_rs2 = '0; ID_rs1_used = 0; ID_rs2_used = 0;
    EX_is_load = 0; EX_rd = '0; EX_br_taken = 0; EX_br_target = '0;
    EX_mc_start = 0; mc_done = 0; halt_req = 0; resume_req = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    EX_br_taken = 1; EX_br_target = 32'hDEAD_BEEF; EX_mc_start = 1; halt_req = 1;
    probe();
    for (int i = 0; i < 2; i++) begin
      chk("rst_jmp_vld", i, {31'd0, jv_o[i]}, 32'd0);
      chk("rst_jmp_addr", i, addr_o[i], 32'd0);
      chk("rst_hold", i, {31'd0, hold_o[i]}, 32'd0);
    end
    tick(); tick();
    idle(); rst_n = 1;
    probe();
    chk("post_rst_stall", 0, st_o[0], 32'd0);
    tick();

    // load-use via rs2
    EX_is_load = 1; EX_rd = 5'd5; ID_rs2 = 5'd5; ID_rs2_used = 1;
    probe();
    chk("lu_hold", 0, {31'd0, hold_o[0]}, 32'd1);
    chk("lu_bubble", 0, {31'd0, bub_o[0]}, 32'd1);
    chk("lu_pipe_hold", 0, {31'd0, ph_o[0]}, 32'd0);
    tick();
    idle();
    probe();
    chk("lu_one_cycle", 0, {31'd0, hold_o[0]}, 32'd0);
    chk("lu_stall", 0, st_o[0], 32'd1);
    tick();
    // x0 never hazards
    EX_is_load = 1; EX_rd = 5'd0; ID_rs1 = 5'd0; ID_rs2 = 5'd0;
    ID_rs1_used = 1; ID_rs2_used = 1;
    probe();
    chk("x0_no_hold", 0, {31'd0, hold_o[0]}, 32'd0);
    tick();
    idle(); EX_is_load = 1; EX_rd = 5'd7; ID_rs1 = 5'd7; ID_rs1_used = 1; tick();
    idle(); EX_is_load = 1; EX_rd = 5'd7; ID_rs1 = 5'd7; tick();
    idle(); EX_rd = 5'd9; ID_rs2 = 5'd9; ID_rs2_used = 1; tick();

    // branch with simultaneous load-use
    idle(); EX_br_taken = 1; EX_br_target = 32'h0000_0100;
    EX_is_load = 1; EX_rd = 5'd5; ID_rs2 = 5'd5; ID_rs2_used = 1;
    probe();
    chk("br_jmp_vld", 0, {31'd0, jv_o[0]}, 32'd1);
    chk("br_jmp_addr", 0, addr_o[0], 32'h100);
    chk("br_no_hold", 0, {31'd0, hold_o[0]}, 32'd0);
    tick();
    idle();
    probe();
    chk("flush_c2_a", 0, {31'd0, fl_o[0]}, 32'd1);
    chk("flush_c2_b", 1, {31'd0, fl_o[1]}, 32'd0);
    chk("flush_c2_addr", 0, addr_o[0], 32'd0);
    tick();
    probe();
    chk("flush_c3_a", 0, {31'd0, fl_o[0]}, 32'd0);
    tick();
    // redirect during FLUSH restarts the count
    EX_br_taken = 1; EX_br_target = 32'h200; tick();
    EX_br_target = 32'h300; halt_req = 1; tick();
    idle(); tick(); tick();

    // multi-cycle op: mc_done 10 cycles after start; dut_b times out at 8
    EX_mc_start = 1; tick();
    idle();
    for (int k = 0; k < 8; k++) tick();
    probe();
    chk("mc_hold_a", 0, {31'd0, hold_o[0]}, 32'd1);
    chk("to_exit_b", 1, {31'd0, hold_o[1]}, 32'd0);
    chk("to_flag_b", 1, {31'd0, to_o[1]}, 32'd1);
    chk("to_flag_a", 0, {31'd0, to_o[0]}, 32'd0);
    tick();
    mc_done = 1;
    probe();
    chk("mc_done_hold", 0, {31'd0, hold_o[0]}, 32'd1);
    tick();
    idle();
    probe();
    chk("mc_exit_a", 0, {31'd0, hold_o[0]}, 32'd0);
    chk("mc_stall_a", 0, st_o[0], 32'd13);
    chk("mc_stall_b", 1, st_o[1], 32'd11);
    tick();

    // halt requested mid-op is taken after mc_done
    EX_mc_start = 1; tick();
    idle(); halt_req = 1; tick(); tick();
    halt_req = 0; tick();
    mc_done = 1;
    probe();
    chk("halt_deferred", 0, {31'd0, hl_o[0]}, 32'd0);
    tick();
    idle();
    probe();
    chk("halt_taken", 0, {31'd0, hl_o[0]}, 32'd1);
    tick();
    EX_br_taken = 1; EX_br_target = 32'h400;
    probe();
    chk("halt_no_jmp", 0, {31'd0, jv_o[0]}, 32'd0);
    tick();
    idle(); resume_req = 1;
    probe();
    chk("resume_cycle", 0, {31'd0, hl_o[0]}, 32'd1);
    tick();
    idle();
    probe();
    chk("resumed", 0, {31'd0, hl_o[0]}, 32'd0);
    tick();

    // resume while halt_req still high: one RUN cycle then re-halt
    halt_req = 1; tick();
    resume_req = 1; tick();
    resume_req = 0;
    probe();
    chk("rehalt_run", 0, {31'd0, hl_o[0]}, 32'd0);
    tick();
    halt_req = 0;
    probe();
    chk("rehalt", 0, {31'd0, hl_o[0]}, 32'd1);
    tick();
    resume_req = 1; tick();
    idle(); tick();

    // reset mid-MC_WAIT with a pending halt
    EX_mc_start = 1; tick();
    idle(); halt_req = 1; tick();
    halt_req = 0; rst_n = 0;
    probe();
    for (int i = 0; i < 2; i++) begin
      chk("rst_mid_hold", i, {31'd0, hold_o[i]}, 32'd0);
      chk("rst_mid_stall", i, st_o[i], 32'd0);
      chk("rst_mid_to", i, {31'd0, to_o[i]}, 32'd0);
    end
    tick();
    rst_n = 1;
    probe();
    chk("rst_clr_to_b", 1, {31'd0, to_o[1]}, 32'd0);
    tick();
    mc_done = 1; tick();
    idle();
    probe();
    chk("no_stale_halt", 0, {31'd0, hl_o[0]}, 32'd0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
